l2_cache_2way: RTL and testbench
================================

Name: l2_cache_2way

Overview:
- Unified second-level cache between the L1 direct-mapped caches (upstream) and main memory (downstream).
- Services 128-bit line reads and line write-backs from L1.
- 2-way set-associative, write-back, write-allocate, 1-bit LRU per set.
- Memory side uses the same 128-bit line handshake, addressed by line.

Parameters:
SETNUM, 16, number of sets
INDEXLEN, 4, log2(SETNUM)
TAGLEN, 24, line-address tag width = 28 - INDEXLEN

Ports:
clk  in  1  clock, all state on rising edge
proc_reset_n  in  1  asynchronous active-low reset
read  in  1  L1 line read request, level, held until ready
write  in  1  L1 line write request, level, held until ready
addr  in  30  L1 word address; line address = addr[29:2]
wdata  in  128  L1 write line
rdata  out  128  line returned to L1, valid while ready=1
ready  out  1  one-cycle completion pulse to L1
stall  out  1  high whenever state != IDLE
mem_read  out  1  memory line read, held until mem_ready
mem_write  out  1  memory line write, held until mem_ready
mem_addr  out  28  memory line address
mem_wdata  out  128  victim line to memory
mem_rdata  in  128  memory read line
mem_ready  in  1  one-cycle memory completion pulse

Behaviour:
- Address split: index = addr[INDEXLEN+1:2], tag = addr[29:INDEXLEN+2], offset addr[1:0] ignored.
- Per way per set: 128-bit data, tag, valid, dirty. Per set: lru bit naming the way to evict next.
- Reset is asynchronous, on proc_reset_n=0:
  - state=IDLE; all valid/dirty/lru=0.
  - rdata=0, ready=0, stall=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transaction aborts immediately; any memory handshake in flight is dropped.
- All outputs are registered.
- Requests are sampled only in IDLE. If read and write are both high, write wins.
- On acceptance, latch req_is_write, tag, index, wdata.
- States:
  - IDLE: no request -> stay.
    - Hit in way w (valid & tag match): read -> rdata<=line; write -> line<=wdata, dirty=1. Then lru<=~w, go to RESP.
    - Miss: victim v = first invalid way (way0 preferred), else lru.
      - Victim valid & dirty -> WB: mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim line.
      - Else read miss -> ALLOC with mem_read=1, mem_addr={tag,index}.
      - Else write miss -> install wdata in v (valid=1, dirty=1, tag), lru<=~v, go to RESP. No memory fetch, since the whole line is written.
  - WB: hold outputs until mem_ready. Then mem_write=0 and clear victim dirty.
    - Read -> ALLOC, issuing mem_read with {tag,index} on the next cycle.
    - Write -> install wdata as above, go to RESP.
  - ALLOC: hold mem_read until mem_ready. Then install mem_rdata in v (valid=1, dirty=0, tag), rdata<=mem_rdata, lru<=~v, go to RESP.
  - RESP: ready=1 for exactly one cycle, then IDLE. Request inputs are ignored in RESP; L1 re-requests from its own IDLE.
- Latencies:
  - Hit: ready the cycle after acceptance (acceptance edge + 1).
  - Clean read miss: 1 + memory latency + 1.
  - Dirty miss: adds one full WB handshake before the fill.
- mem_read and mem_write are never high together. Memory outputs stay stable while a request is held.
- rdata holds its last value outside RESP. ready is low in every state except RESP.

Optional Feature:
- Macro: L2_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_access[15:0] and perf_miss[15:0], reset to 0.
  - perf_access increments on each accepted request; perf_miss increments on each accepted miss.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold read, addr=30'h0000_0040, memory returns 128'hA5..: mem_read with mem_addr=28'h0000010 -> after mem_ready, ready pulses once with rdata=128'hA5..; set 0 way0 valid, clean.
- Repeat the same read -> no mem_read, ready exactly 1 cycle after acceptance, same rdata.
- L1 write hit to the same line, wdata=128'h1234.. -> ready next cycle, no memory activity, way0 dirty; a later read returns 128'h1234..
- Same set, two further tags after the dirty write: second miss fills way1; third evicts LRU way0 -> mem_write with old tag and 128'h1234.., then mem_read for the new tag, then ready.
- read=1 and write=1 simultaneously -> treated as write; stall high from the cycle after acceptance until after ready.
- Assert proc_reset_n=0 during ALLOC -> mem_read, ready, stall drop asynchronously; a following read of the previous hit line misses.

Source files
------------

// File: rtl/l2_cache_2way_if.sv
// ============================================================================
//  Module      : l2_cache_2way_if
//  Description : Line-transfer bus for the L2 cache. Carries the L1-side
//                request/response handshake and the memory-side line
//                handshake.
//                  master - environment view (drives L1 requests and memory
//                           responses)
//                  slave  - cache view
//                Ports (L1 side) : read, write, addr[29:0], wdata[127:0],
//                                  rdata[127:0], ready, stall
//                Ports (mem side): mem_read, mem_write, mem_addr[27:0],
//                                  mem_wdata[127:0], mem_rdata[127:0],
//                                  mem_ready
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface l2_cache_2way_if;
    logic         read;
    logic         write;
    logic [29:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         ready;
    logic         stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output read, write, addr, wdata, mem_rdata, mem_ready,
        input  rdata, ready, stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  read, write, addr, wdata, mem_rdata, mem_ready,
        output rdata, ready, stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/l2_cache_2way.sv
// ============================================================================
//  Module      : l2_cache_2way
//  Description : Unified 2-way set-associative, write-back, write-allocate
//                L2 cache with 1-bit LRU per set. 128-bit lines on both the
//                L1 side and the memory side.
//                Ports: clk          - clock, rising edge
//                       proc_reset_n - asynchronous active-low reset
//                       bus          - l2_cache_2way_if.slave (L1 + memory)
//                       perf_access, perf_miss - only with L2_PERF_CNT_EN
//                Optional macro L2_PERF_CNT_EN adds saturating 16-bit
//                access/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_cache_2way #(
    parameter int SETNUM   = 16,
    parameter int INDEXLEN = 4,
    parameter int TAGLEN   = 28 - INDEXLEN
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    l2_cache_2way_if.slave    bus
`ifdef L2_PERF_CNT_EN
    ,
    output logic [15:0]       perf_access,
    output logic [15:0]       perf_miss
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_ALLOC = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_is_write;
    logic [TAGLEN-1:0]     r_tag;
    logic [INDEXLEN-1:0]   r_index;
    logic [127:0]          r_wdata;
    logic                  r_victim;

    // Storage: data/tag arrays need no reset; valid/dirty/lru do.
    logic [127:0]          r_data    [2][SETNUM];
    logic [TAGLEN-1:0]     r_tag_arr [2][SETNUM];
    logic [SETNUM-1:0]     r_valid   [2];
    logic [SETNUM-1:0]     r_dirty   [2];
    logic [SETNUM-1:0]     r_lru;

    // Request decode (only meaningful in IDLE)
    logic [INDEXLEN-1:0]   w_req_idx;
    logic [TAGLEN-1:0]     w_req_tag;
    logic                  w_req;
    logic                  w_hit0, w_hit1, w_hit, w_hit_way;
    logic                  w_victim, w_vict_dirty;
    logic [1:0]            w_unused_offset;

    assign w_req_idx       = bus.addr[INDEXLEN+1:2];
    assign w_req_tag       = bus.addr[29:INDEXLEN+2];
    assign w_unused_offset = bus.addr[1:0];
    assign w_req           = bus.read | bus.write;
    assign w_hit0          = r_valid[0][w_req_idx] && (r_tag_arr[0][w_req_idx] == w_req_tag);
    assign w_hit1          = r_valid[1][w_req_idx] && (r_tag_arr[1][w_req_idx] == w_req_tag);
    assign w_hit           = w_hit0 | w_hit1;
    assign w_hit_way       = !w_hit0;
    // Fill an empty way first (way0 preferred), otherwise follow LRU
    assign w_victim        = !r_valid[0][w_req_idx] ? 1'b0 :
                             !r_valid[1][w_req_idx] ? 1'b1 : r_lru[w_req_idx];
    assign w_vict_dirty    = r_valid[w_victim][w_req_idx] && r_dirty[w_victim][w_req_idx];

    // Single write port into the data/tag arrays
    logic                  w_arr_we;
    logic                  w_arr_way;
    logic [INDEXLEN-1:0]   w_arr_idx;
    logic [TAGLEN-1:0]     w_arr_tag;
    logic [127:0]          w_arr_data;

    always_comb begin
        w_arr_we   = 1'b0;
        w_arr_way  = 1'b0;
        w_arr_idx  = w_req_idx;
        w_arr_tag  = w_req_tag;
        w_arr_data = bus.wdata;
        case (r_state)
            S_IDLE: begin
                if (w_req && bus.write) begin
                    if (w_hit) begin
                        w_arr_we  = 1'b1;
                        w_arr_way = w_hit_way;
                    end else if (!w_vict_dirty) begin
                        w_arr_we  = 1'b1;
                        w_arr_way = w_victim;
                    end
                end
            end
            S_WB: begin
                if (bus.mem_ready && r_is_write) begin
                    w_arr_we   = 1'b1;
                    w_arr_way  = r_victim;
                    w_arr_idx  = r_index;
                    w_arr_tag  = r_tag;
                    w_arr_data = r_wdata;
                end
            end
            S_ALLOC: begin
                if (bus.mem_ready) begin
                    w_arr_we   = 1'b1;
                    w_arr_way  = r_victim;
                    w_arr_idx  = r_index;
                    w_arr_tag  = r_tag;
                    w_arr_data = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_data[w_arr_way][w_arr_idx]    <= w_arr_data;
            r_tag_arr[w_arr_way][w_arr_idx] <= w_arr_tag;
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state       <= S_IDLE;
            r_is_write    <= 1'b0;
            r_tag         <= '0;
            r_index       <= '0;
            r_wdata       <= '0;
            r_victim      <= 1'b0;
            r_valid[0]    <= '0;
            r_valid[1]    <= '0;
            r_dirty[0]    <= '0;
            r_dirty[1]    <= '0;
            r_lru         <= '0;
            bus.rdata     <= '0;
            bus.ready     <= 1'b0;
            bus.stall     <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
`ifdef L2_PERF_CNT_EN
            perf_access   <= '0;
            perf_miss     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_write <= bus.write;
                        r_tag      <= w_req_tag;
                        r_index    <= w_req_idx;
                        r_wdata    <= bus.wdata;
                        bus.stall  <= 1'b1;
`ifdef L2_PERF_CNT_EN
                        if (perf_access != 16'hFFFF) perf_access <= perf_access + 16'd1;
                        if (!w_hit && perf_miss != 16'hFFFF) perf_miss <= perf_miss + 16'd1;
`endif
                        if (w_hit) begin
                            if (bus.write) r_dirty[w_hit_way][w_req_idx] <= 1'b1;
                            else           bus.rdata <= r_data[w_hit_way][w_req_idx];
                            r_lru[w_req_idx] <= !w_hit_way;
                            bus.ready        <= 1'b1;
                            r_state          <= S_RESP;
                        end else begin
                            r_victim <= w_victim;
                            if (w_vict_dirty) begin
                                bus.mem_write <= 1'b1;
                                bus.mem_addr  <= {r_tag_arr[w_victim][w_req_idx], w_req_idx};
                                bus.mem_wdata <= r_data[w_victim][w_req_idx];
                                r_state       <= S_WB;
                            end else if (!bus.write) begin
                                bus.mem_read <= 1'b1;
                                bus.mem_addr <= {w_req_tag, w_req_idx};
                                r_state      <= S_ALLOC;
                            end else begin
                                // Full-line write: no fetch needed
                                r_valid[w_victim][w_req_idx] <= 1'b1;
                                r_dirty[w_victim][w_req_idx] <= 1'b1;
                                r_lru[w_req_idx]             <= !w_victim;
                                bus.ready                    <= 1'b1;
                                r_state                      <= S_RESP;
                            end
                        end
                    end
                end
                S_WB: begin
                    if (bus.mem_ready) begin
                        bus.mem_write              <= 1'b0;
                        r_dirty[r_victim][r_index] <= 1'b0;
                        if (!r_is_write) begin
                            bus.mem_read <= 1'b1;
                            bus.mem_addr <= {r_tag, r_index};
                            r_state      <= S_ALLOC;
                        end else begin
                            r_valid[r_victim][r_index] <= 1'b1;
                            r_dirty[r_victim][r_index] <= 1'b1;
                            r_lru[r_index]             <= !r_victim;
                            bus.ready                  <= 1'b1;
                            r_state                    <= S_RESP;
                        end
                    end
                end
                S_ALLOC: begin
                    if (bus.mem_ready) begin
                        bus.mem_read               <= 1'b0;
                        r_valid[r_victim][r_index] <= 1'b1;
                        r_dirty[r_victim][r_index] <= 1'b0;
                        r_lru[r_index]             <= !r_victim;
                        bus.rdata                  <= bus.mem_rdata;
                        bus.ready                  <= 1'b1;
                        r_state                    <= S_RESP;
                    end
                end
                S_RESP: begin
                    bus.ready <= 1'b0;
                    bus.stall <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l2_cache_2way.sv
`default_nettype none

module tb_l2_cache_2way;

    logic clk = 1'b0;
    logic proc_reset_n;

    l2_cache_2way_if bus();

    l2_cache_2way dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: transaction-level cache contents plus memory image
    // ------------------------------------------------------------------
    bit           m_valid [2][16];
    bit           m_dirty [2][16];
    logic [23:0]  m_tag   [2][16];
    logic [127:0] m_data  [2][16];
    bit           m_lru   [16];
    logic [127:0] mem_img [logic [27:0]];

    // Expected outcome of the current transaction
    bit           e_wb, e_fill, e_is_wr;
    logic [27:0]  e_wb_addr, e_fill_addr;
    logic [127:0] e_wb_data, e_rdata;

    function automatic logic [127:0] mem_val(input logic [27:0] la);
        if (mem_img.exists(la)) return mem_img[la];
        return {la, 4'h0, ~la, 4'hF, la, 4'h5, la ^ 28'h5A5A5A5, 4'hC};
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
            end
        for (int s = 0; s < 16; s++) m_lru[s] = 0;
    endfunction

    function automatic void model_txn(input bit wr, input logic [29:0] a, input logic [127:0] wd);
        int idx, hitw, v;
        logic [23:0] tg;
        idx = int'(a[5:2]);
        tg  = a[29:6];
        e_is_wr = wr;
        e_wb    = 0;
        e_fill  = 0;
        hitw    = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[w][idx] && m_tag[w][idx] == tg) hitw = w;
        if (hitw >= 0) begin
            if (wr) begin
                m_data[hitw][idx]  = wd;
                m_dirty[hitw][idx] = 1;
            end else begin
                e_rdata = m_data[hitw][idx];
            end
            m_lru[idx] = (hitw == 0);
        end else begin
            v = !m_valid[0][idx] ? 0 : (!m_valid[1][idx] ? 1 : int'(m_lru[idx]));
            if (m_valid[v][idx] && m_dirty[v][idx]) begin
                e_wb      = 1;
                e_wb_addr = {m_tag[v][idx], 4'(idx)};
                e_wb_data = m_data[v][idx];
                mem_img[e_wb_addr] = e_wb_data;
            end
            if (!wr) begin
                e_fill      = 1;
                e_fill_addr = {tg, 4'(idx)};
                e_rdata     = mem_val(e_fill_addr);
                m_data[v][idx]  = e_rdata;
                m_dirty[v][idx] = 0;
            end else begin
                m_data[v][idx]  = wd;
                m_dirty[v][idx] = 1;
            end
            m_valid[v][idx] = 1;
            m_tag[v][idx]   = tg;
            m_lru[idx]      = (v == 0);
        end
    endfunction

    // Observations from the last transaction (for literal pins)
    int           obs_cyc, obs_nmem;
    logic [127:0] obs_rdata, obs_wb_data;
    logic [27:0]  obs_wb_addr, obs_fill_addr;

    // ------------------------------------------------------------------
    // One L1 transaction: drives the request, acts as memory, and
    // compares every cycle against the model's expectation.
    // ------------------------------------------------------------------
    task automatic do_txn(input bit rd, input bit wr, input logic [29:0] a, input logic [127:0] wd);
        int cyc, wait_cnt, exp_cyc;
        bit got, wb_seen, fill_seen, cur_wr;
        logic [27:0]  cur_addr;
        logic [127:0] cur_wdata;
        model_txn(wr, a, wd);
        bus.read  = rd;
        bus.write = wr;
        bus.addr  = a;
        bus.wdata = wd;
        cyc = 0; got = 0; wait_cnt = -1; exp_cyc = 1;
        wb_seen = 0; fill_seen = 0; cur_wr = 0; cur_addr = '0; cur_wdata = '0;
        obs_nmem = 0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            bus.mem_ready = 1'b0;
            chk("stall_busy", bus.stall, 1);
            chk("mem_excl", bus.mem_read & bus.mem_write, 0);
            if (bus.ready) begin
                got       = 1;
                obs_cyc   = cyc;
                obs_rdata = bus.rdata;
                chk("latency", cyc, exp_cyc);
                if (!e_is_wr) chk("rdata", bus.rdata, e_rdata);
                chk("wb_done", wb_seen, e_wb);
                chk("fill_done", fill_seen, e_fill);
                chk("mem_quiet_at_ready", {bus.mem_read, bus.mem_write}, 0);
                bus.read  = 1'b0;
                bus.write = 1'b0;
            end else begin
                if (wait_cnt < 0) begin
                    if (bus.mem_write) begin
                        chk("wb_expected", e_wb && !wb_seen, 1);
                        wb_seen = 1; cur_wr = 1;
                        obs_wb_addr = bus.mem_addr;
                        obs_wb_data = bus.mem_wdata;
                        chk("wb_addr", bus.mem_addr, e_wb_addr);
                        chk("wb_data", bus.mem_wdata, e_wb_data);
                    end else if (bus.mem_read) begin
                        chk("fill_expected", e_fill && !fill_seen && (wb_seen == e_wb), 1);
                        fill_seen = 1; cur_wr = 0;
                        obs_fill_addr = bus.mem_addr;
                        chk("fill_addr", bus.mem_addr, e_fill_addr);
                    end
                    if (bus.mem_write || bus.mem_read) begin
                        obs_nmem++;
                        cur_addr  = bus.mem_addr;
                        cur_wdata = bus.mem_wdata;
                        wait_cnt  = $urandom_range(0, 3);
                        exp_cyc  += wait_cnt + 1;
                    end
                end else begin
                    chk("mem_hold", {bus.mem_read, bus.mem_write, bus.mem_addr},
                        {!cur_wr, cur_wr, cur_addr});
                    if (cur_wr) chk("mem_wdata_hold", bus.mem_wdata, cur_wdata);
                end
                if (wait_cnt == 0) begin
                    bus.mem_rdata = mem_val(cur_addr);
                    bus.mem_ready = 1'b1;
                    wait_cnt = -1;
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                end
            end
        end
        chk("ready_timeout", got, 1);
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("ready_one_cycle", bus.ready, 0);
        chk("stall_idle", bus.stall, 0);
    endtask

    localparam logic [127:0] c_a5   = {16{8'hA5}};
    localparam logic [127:0] c_1234 = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;
    localparam logic [127:0] c_w7   = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;

    initial begin
        bit seen;
        proc_reset_n  = 1'b0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", bus.ready, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_mem_rw", {bus.mem_read, bus.mem_write}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.rdata, 0);
        repeat (2) @(posedge clk);
        #1 proc_reset_n = 1'b1;
        @(posedge clk); #1;

        // Cold read miss
        mem_img[28'h0000010] = c_a5;
        do_txn(1, 0, 30'h0000_0040, '0);
        chk("cold_fill_addr", obs_fill_addr, 28'h0000010);
        chk("cold_rdata", obs_rdata, c_a5);
        // Repeat -> hit
        do_txn(1, 0, 30'h0000_0040, '0);
        chk("hit_latency", obs_cyc, 1);
        chk("hit_no_mem", obs_nmem, 0);
        chk("hit_rdata", obs_rdata, c_a5);
        // Write hit
        do_txn(0, 1, 30'h0000_0040, c_1234);
        chk("whit_latency", obs_cyc, 1);
        chk("whit_no_mem", obs_nmem, 0);
        do_txn(1, 0, 30'h0000_0041, '0);
        chk("whit_readback", obs_rdata, c_1234);
        // Second tag fills way1
        do_txn(1, 0, 30'h0000_0080, '0);
        chk("way1_fill_addr", obs_fill_addr, 28'h0000020);
        chk("way1_nmem", obs_nmem, 1);
        // Third tag evicts dirty way0
        do_txn(1, 0, 30'h0000_00C0, '0);
        chk("evict_wb_addr", obs_wb_addr, 28'h0000010);
        chk("evict_wb_data", obs_wb_data, c_1234);
        chk("evict_fill_addr", obs_fill_addr, 28'h0000030);
        chk("evict_nmem", obs_nmem, 2);
        // read+write together -> write (clean victim, no memory)
        do_txn(1, 1, 30'h0000_0100, c_w7);
        chk("rw_latency", obs_cyc, 1);
        chk("rw_no_mem", obs_nmem, 0);
        do_txn(1, 0, 30'h0000_0100, '0);
        chk("rw_readback", obs_rdata, c_w7);

        // Reset during ALLOC
        bus.read = 1'b1;
        bus.addr = 30'h0000_0140;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus.mem_read;
        end
        chk("alloc_reached", seen, 1);
        #2 proc_reset_n = 1'b0;
        #1;
        chk("arst_mem_read", bus.mem_read, 0);
        chk("arst_ready", bus.ready, 0);
        chk("arst_stall", bus.stall, 0);
        bus.read = 1'b0;
        model_reset();
        @(posedge clk); #1;
        proc_reset_n = 1'b1;
        @(posedge clk); #1;
        do_txn(1, 0, 30'h0000_0040, '0);
        chk("post_rst_miss", obs_nmem, 1);
        chk("post_rst_fill_addr", obs_fill_addr, 28'h0000010);
        chk("post_rst_rdata", obs_rdata, c_1234);

        // Randomized traffic with heavy set conflicts
        for (int n = 0; n < 400; n++) begin
            logic [23:0]  tg;
            logic [3:0]   ix;
            logic [1:0]   off;
            logic [127:0] wd;
            int           kind;
            tg   = 24'($urandom_range(0, 5));
            ix   = 4'($urandom_range(0, 3));
            off  = 2'($urandom_range(0, 3));
            wd   = {$urandom, $urandom, $urandom, $urandom};
            kind = $urandom_range(0, 3);
            do_txn(kind == 0 || kind >= 2, kind <= 1, {tg, ix, off}, wd);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                chk("idle_ready_low", bus.ready, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
